// File: rtl/interrupt_priority_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_priority_core_if
//  Description : Signal bundle between the 8259A command-word front end and
//                the interrupt priority core.
//                slave  : the priority core (consumes requests and command
//                         words, produces INT, vector and status registers)
//                master : the front end / CPU side driving it
//  Signals     : IR[7:0] requests, INTA (active low), ICW1/ICW2/ICW4/OCW1/
//                OCW2 command words, ICWFlags (4'hF = init done), ocw2Strobe,
//                INT, vectorOut[7:0], vectorValid, ISR[7:0], IRR[7:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_priority_core_if;
    logic [7:0] IR;
    logic       INTA;
    logic [7:0] ICW1;
    logic [7:0] ICW2;
    logic [7:0] ICW4;
    logic [7:0] OCW1;
    logic [7:0] OCW2;
    logic [3:0] ICWFlags;
    logic       ocw2Strobe;
    logic       INT;
    logic [7:0] vectorOut;
    logic       vectorValid;
    logic [7:0] ISR;
    logic [7:0] IRR;

    modport slave (
        input  IR, INTA, ICW1, ICW2, ICW4, OCW1, OCW2, ICWFlags, ocw2Strobe,
        output INT, vectorOut, vectorValid, ISR, IRR
    );

    modport master (
        output IR, INTA, ICW1, ICW2, ICW4, OCW1, OCW2, ICWFlags, ocw2Strobe,
        input  INT, vectorOut, vectorValid, ISR, IRR
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_priority_core.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_priority_core
//  Description : 8259A request/in-service core. Latches IR requests (edge or
//                level), masks with OCW1, resolves priority relative to a
//                rotating lowest-priority pointer, drives INT, runs the
//                two-pulse INTA acknowledge and executes OCW2 EOI/rotation.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-high reset
//                bus   - interrupt_priority_core_if.slave (requests, command
//                        words, INT, vector, ISR/IRR status)
//  Options     : AUTO_EOI_EN - when defined, ICW4[1] AEOI is honored and
//                OCW2 codes 100/000 set/clear rotate-on-AEOI.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_priority_core (
    input  wire                          clk,
    input  wire                          reset,
    interrupt_priority_core_if.slave     bus
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_WAIT2 = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [2:0] r_lp;
    logic [2:0] r_level;
    logic       r_spurious;
    logic       r_rotate_aeoi;
    logic [7:0] r_ir_prev;
    logic       r_inta_prev;
    logic       r_int;
    logic [7:0] r_vector;
    logic       r_vvalid;

    // Rotate so that the highest-priority level (lp+1) lands on bit 0.
    function automatic logic [7:0] rot_by(input logic [7:0] v, input logic [2:0] s);
        logic [15:0] dbl;
        dbl = {v, v} >> s;
        return dbl[7:0];
    endfunction

    // {found, position of lowest set bit}
    function automatic logic [3:0] first_set(input logic [7:0] v);
        logic [3:0] res;
        res = 4'b0000;
        for (int j = 7; j >= 0; j--) begin
            if (v[j]) res = {1'b1, j[2:0]};
        end
        return res;
    endfunction

    logic [2:0] w_base;
    logic [3:0] w_win_enc;
    logic [3:0] w_isr_enc;
    logic       w_win_vld;
    logic       w_isr_vld;
    logic [2:0] w_win_idx;
    logic [2:0] w_isr_idx;
    logic       w_int_cond;
    logic       w_aeoi_en;

    assign w_base    = r_lp + 3'd1;
    assign w_win_enc = first_set(rot_by(r_irr & ~bus.OCW1, w_base));
    assign w_isr_enc = first_set(rot_by(r_isr, w_base));
    assign w_win_vld = w_win_enc[3];
    assign w_isr_vld = w_isr_enc[3];
    assign w_win_idx = w_win_enc[2:0] + w_base;
    assign w_isr_idx = w_isr_enc[2:0] + w_base;
    // Rotated positions are priority ranks: smaller rank = higher priority.
    assign w_int_cond = w_win_vld && (!w_isr_vld || (w_win_enc[2:0] < w_isr_enc[2:0]));

`ifdef AUTO_EOI_EN
    assign w_aeoi_en = bus.ICW4[1];
`else
    assign w_aeoi_en = 1'b0;
`endif

    logic       w_inta_fall;
    logic [7:0] w_ack_mask;
    logic [7:0] w_eoi_mask;
    logic [7:0] w_aeoi_mask;
    logic [2:0] w_lp_nxt;
    logic       w_ocw2_lp;
    logic       w_rot_nxt;
    logic [0:0] w_state_nxt;
    logic [2:0] w_level_nxt;
    logic       w_spur_nxt;
    logic [7:0] w_vec_nxt;
    logic       w_vvalid_nxt;
    logic [7:0] w_irr_src;
    logic [7:0] w_irr_nxt;
    logic [7:0] w_isr_nxt;

    always_comb begin
        w_inta_fall  = r_inta_prev & ~bus.INTA;
        w_ack_mask   = 8'h00;
        w_eoi_mask   = 8'h00;
        w_aeoi_mask  = 8'h00;
        w_lp_nxt     = r_lp;
        w_ocw2_lp    = 1'b0;
        w_rot_nxt    = r_rotate_aeoi;
        w_state_nxt  = r_state;
        w_level_nxt  = r_level;
        w_spur_nxt   = r_spurious;
        w_vec_nxt    = r_vector;
        w_vvalid_nxt = 1'b0;

        if (bus.ocw2Strobe) begin
            case (bus.OCW2[7:5])
                3'b001: if (w_isr_vld) w_eoi_mask = 8'h01 << w_isr_idx;
                3'b011: w_eoi_mask = 8'h01 << bus.OCW2[2:0];
                3'b101: begin
                    if (w_isr_vld) begin
                        w_eoi_mask = 8'h01 << w_isr_idx;
                        w_lp_nxt   = w_isr_idx;
                        w_ocw2_lp  = 1'b1;
                    end
                end
                3'b111: begin
                    w_eoi_mask = 8'h01 << bus.OCW2[2:0];
                    w_lp_nxt   = bus.OCW2[2:0];
                    w_ocw2_lp  = 1'b1;
                end
                3'b110: begin
                    w_lp_nxt  = bus.OCW2[2:0];
                    w_ocw2_lp = 1'b1;
                end
`ifdef AUTO_EOI_EN
                3'b100: w_rot_nxt = 1'b1;
                3'b000: w_rot_nxt = 1'b0;
`else
                3'b100: w_rot_nxt = 1'b0;
                3'b000: w_rot_nxt = 1'b0;
`endif
                default: ;
            endcase
        end

        case (r_state)
            c_IDLE: begin
                if (w_inta_fall) begin
                    w_state_nxt = c_WAIT2;
                    if (w_win_vld) begin
                        w_level_nxt = w_win_idx;
                        w_spur_nxt  = 1'b0;
                        w_ack_mask  = 8'h01 << w_win_idx;
                    end else begin
                        w_level_nxt = 3'd7;
                        w_spur_nxt  = 1'b1;
                    end
                end
            end
            c_WAIT2: begin
                if (w_inta_fall) begin
                    w_state_nxt  = c_IDLE;
                    w_vec_nxt    = {bus.ICW2[7:3], r_level};
                    w_vvalid_nxt = 1'b1;
                    if (w_aeoi_en && !r_spurious) begin
                        w_aeoi_mask = 8'h01 << r_level;
                        // An explicit OCW2 pointer write in the same cycle takes precedence.
                        if (r_rotate_aeoi && !w_ocw2_lp) w_lp_nxt = r_level;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase

        w_irr_src = bus.ICW1[3] ? bus.IR : (r_irr | (bus.IR & ~r_ir_prev));
        w_irr_nxt = w_irr_src & ~w_ack_mask;
        // Clears first, then the acknowledge set, so a colliding set wins.
        w_isr_nxt = (r_isr & ~w_eoi_mask & ~w_aeoi_mask) | w_ack_mask;
    end

    always_ff @(posedge clk) begin
        if (reset || (bus.ICWFlags != 4'hF)) begin
            r_state       <= c_IDLE;
            r_irr         <= 8'h00;
            r_isr         <= 8'h00;
            r_lp          <= 3'd7;
            r_level       <= 3'd0;
            r_spurious    <= 1'b0;
            r_rotate_aeoi <= 1'b0;
            r_ir_prev     <= 8'h00;
            r_inta_prev   <= 1'b1;
            r_int         <= 1'b0;
            r_vector      <= 8'h00;
            r_vvalid      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_irr         <= w_irr_nxt;
            r_isr         <= w_isr_nxt;
            r_lp          <= w_lp_nxt;
            r_level       <= w_level_nxt;
            r_spurious    <= w_spur_nxt;
            r_rotate_aeoi <= w_rot_nxt;
            r_ir_prev     <= bus.IR;
            r_inta_prev   <= bus.INTA;
            // INT is judged on the registered state, and held low in WAIT2.
            r_int         <= (w_state_nxt == c_IDLE) && w_int_cond;
            r_vector      <= w_vec_nxt;
            r_vvalid      <= w_vvalid_nxt;
        end
    end

    assign bus.INT         = r_int;
    assign bus.vectorOut   = r_vector;
    assign bus.vectorValid = r_vvalid;
    assign bus.ISR         = r_isr;
    assign bus.IRR         = r_irr;

    logic w_unused_bits;
    assign w_unused_bits = ^{bus.ICW1[7:4], bus.ICW1[2:0], bus.ICW2[2:0], bus.ICW4, bus.OCW2[4:3]};

endmodule
`default_nettype wire

// File: tb/tb_interrupt_priority_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_priority_core
//  Description : Self-checking bench for interrupt_priority_core: directed
//                scenarios with fixed expectations plus randomized traffic
//                compared against a behavioural model of the priority rules.
//                Honors AUTO_EOI_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_priority_core;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    interrupt_priority_core_if bus ();

    interrupt_priority_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_irr, m_isr, m_vec, m_irprev;
    logic       m_int, m_vv, m_intaprev, m_rot, m_wait2, m_spur;
    int         m_lp, m_level;

    // Highest-priority set level, scanning lp+1, lp+2, ... lp (mod 8).
    function automatic int prio_top(logic [7:0] v, int lp);
        for (int k = 1; k <= 8; k++) begin
            if (v[(lp + k) % 8]) return (lp + k) % 8;
        end
        return -1;
    endfunction

    function automatic int rank_of(int idx, int lp);
        return (idx - lp + 7) % 8;
    endfunction

    always @(posedge clk) begin : ref_model
        int win, itop, ack, nlp, nlevel;
        logic [7:0] nirr, nisr, nvec;
        bit nwait, fall, cond, lp_by_ocw, aeoi_en, nrot, nspur, nvv;
        if (reset || bus.ICWFlags != 4'hF) begin
            m_irr <= 8'h00; m_isr <= 8'h00; m_vec <= 8'h00; m_irprev <= 8'h00;
            m_int <= 1'b0; m_vv <= 1'b0; m_intaprev <= 1'b1; m_rot <= 1'b0;
            m_wait2 <= 1'b0; m_spur <= 1'b0; m_lp <= 7; m_level <= 0;
        end else begin
            win  = prio_top(m_irr & ~bus.OCW1, m_lp);
            itop = prio_top(m_isr, m_lp);
            cond = (win >= 0) && (itop < 0 || rank_of(win, m_lp) < rank_of(itop, m_lp));
            fall = m_intaprev && !bus.INTA;
            nisr = m_isr; nlp = m_lp; nrot = m_rot; lp_by_ocw = 0; ack = -1;
            nwait = m_wait2; nvv = 0; nvec = m_vec; nlevel = m_level; nspur = m_spur;
`ifdef AUTO_EOI_EN
            aeoi_en = bus.ICW4[1];
`else
            aeoi_en = 0;
`endif
            if (bus.ocw2Strobe) begin
                case (bus.OCW2[7:5])
                    3'b001: if (itop >= 0) nisr[itop] = 1'b0;
                    3'b011: nisr[bus.OCW2[2:0]] = 1'b0;
                    3'b101: if (itop >= 0) begin nisr[itop] = 1'b0; nlp = itop; lp_by_ocw = 1; end
                    3'b111: begin nisr[bus.OCW2[2:0]] = 1'b0; nlp = bus.OCW2[2:0]; lp_by_ocw = 1; end
                    3'b110: begin nlp = bus.OCW2[2:0]; lp_by_ocw = 1; end
`ifdef AUTO_EOI_EN
                    3'b100: nrot = 1;
                    3'b000: nrot = 0;
`endif
                    default: ;
                endcase
            end
            if (m_wait2 && fall) begin
                nvec = {bus.ICW2[7:3], 3'(m_level)};
                nvv = 1; nwait = 0;
                if (aeoi_en && !m_spur) begin
                    nisr[m_level] = 1'b0;
                    if (m_rot && !lp_by_ocw) nlp = m_level;
                end
            end else if (!m_wait2 && fall) begin
                nwait = 1;
                if (win >= 0) begin ack = win; nlevel = win; nspur = 0; end
                else begin nlevel = 7; nspur = 1; end
            end
            nirr = bus.ICW1[3] ? bus.IR : (m_irr | (bus.IR & ~m_irprev));
            if (ack >= 0) begin nirr[ack] = 1'b0; nisr[ack] = 1'b1; end
            m_int <= !nwait && cond;
            m_irr <= nirr; m_isr <= nisr; m_lp <= nlp; m_rot <= nrot;
            m_wait2 <= nwait; m_vec <= nvec; m_vv <= nvv; m_level <= nlevel; m_spur <= nspur;
            m_irprev <= bus.IR; m_intaprev <= bus.INTA;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_defaults();
        bus.IR = 8'h00; bus.INTA = 1'b1; bus.ICW1 = 8'h00; bus.ICW2 = 8'h40;
        bus.ICW4 = 8'h00; bus.OCW1 = 8'h00; bus.OCW2 = 8'h00;
        bus.ICWFlags = 4'hF; bus.ocw2Strobe = 1'b0;
    endtask

    task automatic do_reset();
        set_defaults();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    // Two INTA pulses; returns when the vector of the second fall is visible.
    task automatic ack();
        bus.INTA = 1'b0; cyc();
        bus.INTA = 1'b1; cyc();
        bus.INTA = 1'b0; cyc();
        bus.INTA = 1'b1;
    endtask

    task automatic ocw2(input logic [7:0] v);
        bus.OCW2 = v; bus.ocw2Strobe = 1'b1; cyc();
        bus.ocw2Strobe = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        bus.IR = 8'hFF; cyc();
        reset = 1'b1; bus.IR = 8'h00; cyc();
        if (bus.IRR !== 8'h00) begin n_err++; $display("FAIL reset_irr: got %h want 00", bus.IRR); end n_cmp++;
        if (bus.ISR !== 8'h00) begin n_err++; $display("FAIL reset_isr: got %h want 00", bus.ISR); end n_cmp++;
        if (bus.INT !== 1'b0) begin n_err++; $display("FAIL reset_int: got %b want 0", bus.INT); end n_cmp++;
        if (bus.vectorOut !== 8'h00 || bus.vectorValid !== 1'b0) begin n_err++;
            $display("FAIL reset_vec: got %h/%b want 00/0", bus.vectorOut, bus.vectorValid); end n_cmp++;
        reset = 1'b0;
    endtask

    task automatic test_edge_ack();
        do_reset();
        bus.IR = 8'h08; cyc();
        if (bus.IRR !== 8'h08 || bus.INT !== 1'b0) begin n_err++;
            $display("FAIL edge_irr: got %h/%b want 08/0", bus.IRR, bus.INT); end n_cmp++;
        bus.IR = 8'h00; cyc();
        if (bus.INT !== 1'b1) begin n_err++; $display("FAIL edge_int: got %b want 1", bus.INT); end n_cmp++;
        bus.INTA = 1'b0; cyc();
        if (bus.INT !== 1'b0 || bus.ISR !== 8'h08 || bus.IRR !== 8'h00) begin n_err++;
            $display("FAIL edge_ack1: got int %b isr %h irr %h want 0 08 00", bus.INT, bus.ISR, bus.IRR); end n_cmp++;
        bus.INTA = 1'b1; cyc();
        bus.INTA = 1'b0; cyc();
        if (bus.vectorValid !== 1'b1 || bus.vectorOut !== 8'h43) begin n_err++;
            $display("FAIL edge_vec: got %h/%b want 43/1", bus.vectorOut, bus.vectorValid); end n_cmp++;
        cyc();
        if (bus.vectorValid !== 1'b0 || bus.vectorOut !== 8'h43 || bus.ISR !== 8'h08 || bus.INT !== 1'b0) begin n_err++;
            $display("FAIL edge_after: got vv %b vec %h isr %h int %b want 0 43 08 0",
                     bus.vectorValid, bus.vectorOut, bus.ISR, bus.INT); end n_cmp++;
        // Holding INTA low must not start another acknowledge.
        bus.INTA = 1'b0; cyc(); cyc(); cyc();
        if (bus.vectorValid !== 1'b0) begin n_err++; $display("FAIL edge_hold: got vv %b want 0", bus.vectorValid); end n_cmp++;
        bus.INTA = 1'b1; cyc();
    endtask

    task automatic test_mask();
        do_reset();
        bus.OCW1 = 8'h02; bus.IR = 8'h22; cyc();
        bus.IR = 8'h00; cyc();
        ack();
        if (bus.vectorOut !== 8'h45 || bus.vectorValid !== 1'b1) begin n_err++;
            $display("FAIL mask_vec: got %h/%b want 45/1", bus.vectorOut, bus.vectorValid); end n_cmp++;
        cyc();
        if (bus.IRR !== 8'h02 || bus.INT !== 1'b0 || bus.ISR !== 8'h20) begin n_err++;
            $display("FAIL mask_state: got irr %h int %b isr %h want 02 0 20", bus.IRR, bus.INT, bus.ISR); end n_cmp++;
    endtask

    task automatic test_nesting();
        do_reset();
        bus.IR = 8'h10; cyc(); bus.IR = 8'h00; cyc();
        ack(); cyc();
        if (bus.ISR !== 8'h10) begin n_err++; $display("FAIL nest_isr4: got %h want 10", bus.ISR); end n_cmp++;
        bus.IR = 8'h04; cyc(); bus.IR = 8'h00; cyc();
        if (bus.INT !== 1'b1) begin n_err++; $display("FAIL nest_int_hi: got %b want 1", bus.INT); end n_cmp++;
        ack(); cyc();
        if (bus.ISR !== 8'h14) begin n_err++; $display("FAIL nest_isr24: got %h want 14", bus.ISR); end n_cmp++;
        ocw2(8'h64);
        if (bus.ISR !== 8'h04) begin n_err++; $display("FAIL nest_seoi: got %h want 04", bus.ISR); end n_cmp++;
        bus.IR = 8'h40; cyc(); bus.IR = 8'h00; cyc(); cyc();
        if (bus.INT !== 1'b0 || bus.IRR !== 8'h40) begin n_err++;
            $display("FAIL nest_int_lo: got int %b irr %h want 0 40", bus.INT, bus.IRR); end n_cmp++;
        ocw2(8'h20);
        if (bus.ISR !== 8'h00) begin n_err++; $display("FAIL nest_nseoi: got %h want 00", bus.ISR); end n_cmp++;
        cyc();
        if (bus.INT !== 1'b1) begin n_err++; $display("FAIL nest_int_after: got %b want 1", bus.INT); end n_cmp++;
    endtask

    task automatic test_rotation();
        do_reset();
        ocw2(8'hC3);
        bus.IR = 8'h14; cyc(); bus.IR = 8'h00; cyc();
        ack();
        if (bus.vectorOut !== 8'h44) begin n_err++; $display("FAIL rot_vec4: got %h want 44", bus.vectorOut); end n_cmp++;
        cyc();
        if (bus.ISR !== 8'h10 || bus.IRR !== 8'h04) begin n_err++;
            $display("FAIL rot_state: got isr %h irr %h want 10 04", bus.ISR, bus.IRR); end n_cmp++;
        ocw2(8'hE4);
        if (bus.ISR !== 8'h00) begin n_err++; $display("FAIL rot_seoi: got %h want 00", bus.ISR); end n_cmp++;
        bus.IR = 8'h20; cyc(); bus.IR = 8'h00; cyc();
        ack();
        if (bus.vectorOut !== 8'h45) begin n_err++; $display("FAIL rot_vec5: got %h want 45", bus.vectorOut); end n_cmp++;
    endtask

    task automatic test_aeoi();
        logic [7:0] exp_isr;
`ifdef AUTO_EOI_EN
        exp_isr = 8'h00;
`else
        exp_isr = 8'h01;
`endif
        do_reset();
        bus.ICW4 = 8'h02;
        bus.IR = 8'h01; cyc(); bus.IR = 8'h00; cyc();
        ack();
        if (bus.vectorOut !== 8'h40) begin n_err++; $display("FAIL aeoi_vec: got %h want 40", bus.vectorOut); end n_cmp++;
        cyc();
        if (bus.ISR !== exp_isr) begin n_err++; $display("FAIL aeoi_isr: got %h want %h", bus.ISR, exp_isr); end n_cmp++;
        bus.ICW4 = 8'h00;
    endtask

    task automatic test_spurious();
        do_reset();
        ack();
        if (bus.vectorOut !== 8'h47 || bus.vectorValid !== 1'b1) begin n_err++;
            $display("FAIL spur_vec: got %h/%b want 47/1", bus.vectorOut, bus.vectorValid); end n_cmp++;
        cyc();
        if (bus.ISR !== 8'h00 || bus.IRR !== 8'h00) begin n_err++;
            $display("FAIL spur_state: got isr %h irr %h want 00 00", bus.ISR, bus.IRR); end n_cmp++;
    endtask

    task automatic test_reinit();
        do_reset();
        bus.IR = 8'h02; cyc(); bus.IR = 8'h00; cyc();
        bus.INTA = 1'b0; cyc();
        if (bus.ISR !== 8'h02) begin n_err++; $display("FAIL reinit_isr: got %h want 02", bus.ISR); end n_cmp++;
        bus.INTA = 1'b1; bus.ICWFlags = 4'h0; cyc();
        if (bus.IRR !== 8'h00 || bus.ISR !== 8'h00 || bus.INT !== 1'b0) begin n_err++;
            $display("FAIL reinit_clear: got irr %h isr %h int %b want 00 00 0", bus.IRR, bus.ISR, bus.INT); end n_cmp++;
        bus.ICWFlags = 4'hF; bus.INTA = 1'b0; cyc();
        if (bus.vectorValid !== 1'b0) begin n_err++; $display("FAIL reinit_novec: got %b want 0", bus.vectorValid); end n_cmp++;
        bus.INTA = 1'b1; cyc();
    endtask

    task automatic test_level();
        do_reset();
        bus.ICW1 = 8'h08; bus.IR = 8'h01; cyc();
        if (bus.IRR !== 8'h01) begin n_err++; $display("FAIL lvl_irr: got %h want 01", bus.IRR); end n_cmp++;
        cyc();
        if (bus.INT !== 1'b1) begin n_err++; $display("FAIL lvl_int: got %b want 1", bus.INT); end n_cmp++;
        ack(); cyc();
        if (bus.ISR !== 8'h01 || bus.IRR !== 8'h01 || bus.INT !== 1'b0) begin n_err++;
            $display("FAIL lvl_ack: got isr %h irr %h int %b want 01 01 0", bus.ISR, bus.IRR, bus.INT); end n_cmp++;
        ocw2(8'h20); cyc();
        if (bus.ISR !== 8'h00 || bus.INT !== 1'b1) begin n_err++;
            $display("FAIL lvl_rereq: got isr %h int %b want 00 1", bus.ISR, bus.INT); end n_cmp++;
        bus.IR = 8'h00; bus.ICW1 = 8'h00;
    endtask

    task automatic test_random();
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            bus.ICW1 = (mode == 1) ? 8'h08 : 8'h00;
            bus.ICW4 = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h00;
            bus.ICW2 = 8'($urandom);
            for (int c = 0; c < 800; c++) begin
                cyc();
                if (bus.IRR !== m_irr) begin n_err++; $display("FAIL rand_irr c%0d: got %h want %h", c, bus.IRR, m_irr); end n_cmp++;
                if (bus.ISR !== m_isr) begin n_err++; $display("FAIL rand_isr c%0d: got %h want %h", c, bus.ISR, m_isr); end n_cmp++;
                if (bus.INT !== m_int) begin n_err++; $display("FAIL rand_int c%0d: got %b want %b", c, bus.INT, m_int); end n_cmp++;
                if (bus.vectorValid !== m_vv) begin n_err++; $display("FAIL rand_vv c%0d: got %b want %b", c, bus.vectorValid, m_vv); end n_cmp++;
                if (bus.vectorOut !== m_vec) begin n_err++; $display("FAIL rand_vec c%0d: got %h want %h", c, bus.vectorOut, m_vec); end n_cmp++;
                bus.IR         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ((mode == 1) ? bus.IR : 8'h00);
                bus.INTA       = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                bus.ocw2Strobe = ($urandom_range(0, 7) == 0);
                bus.OCW2       = 8'($urandom);
                if ($urandom_range(0, 31) == 0) bus.OCW1 = 8'($urandom) & 8'($urandom);
                bus.ICWFlags   = ($urandom_range(0, 199) == 0) ? 4'h0 : 4'hF;
            end
        end
        set_defaults();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        set_defaults();
        test_reset();
        test_edge_ack();
        test_mask();
        test_nesting();
        test_rotation();
        test_aeoi();
        test_spurious();
        test_reinit();
        test_level();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
